// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one I2C Master between NREQ clients.
// Latches the winner's fields, launches the master, retries errors, enforces a timeout, returns status.
module i2c_bus_arbiter #(
    parameter int NREQ      = 2,
    parameter int MAX_RETRY = 2,
    parameter int GAP_CYC   = 250,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [NREQ-1:0]      Req,
    input  logic [7*NREQ-1:0]    Req_adr,
    input  logic [NREQ-1:0]      Req_rw,
    input  logic [8*NREQ-1:0]    Req_pointer,
    input  logic [NREQ-1:0]      Req_setptr,
    input  logic [16*NREQ-1:0]   Req_wdata,
    output logic [NREQ-1:0]      Gnt,
    output logic [NREQ-1:0]      Done,
    output logic [1:0]           Stat,
    output logic [15:0]          Rdata,
    output logic                 Busy,
    output logic                 M_start,
    output logic                 M_rw,
    output logic                 M_set_pointer,
    output logic [6:0]           M_adr,
    output logic [7:0]           M_pointer,
    output logic [7:0]           M_data_in,
    output logic [7:0]           M_data_in2,
    input  logic                 M_ready,
    input  logic                 M_error,
    input  logic [7:0]           M_data_out1,
    input  logic [7:0]           M_data_out2
);
    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, GAP, FINISH} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic [1:0]      stat_q, stat_d;
    logic [15:0]     rdata_q, rdata_d, tmo_q, tmo_d;
    logic [7:0]      retry_q, retry_d;
    logic            busy_q;
    logic            start_q, start_d, rw_q, rw_d, sp_q, sp_d;
    logic [6:0]      adr_q, adr_d;
    logic [7:0]      ptr_q, ptr_d, din_q, din_d, din2_q, din2_d;

    logic [6:0]      adr_a  [NREQ];
    logic [7:0]      ptr_a  [NREQ];
    logic [15:0]     wd_a   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign adr_a[i] = Req_adr[7*i +: 7];
        assign ptr_a[i] = Req_pointer[8*i +: 8];
        assign wd_a[i]  = Req_wdata[16*i +: 16];
    end

    // Scan from farthest to nearest after last so the nearest pending requester wins.
    logic [IW-1:0] pick, cand;
    logic          pick_vld;
    always_comb begin
        pick     = last_q;
        cand     = last_q;
        pick_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (Req[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        stat_d  = stat_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q + 16'd1;
        retry_d = retry_q;
        start_d = start_q;
        rw_d    = rw_q;
        sp_d    = sp_q;
        adr_d   = adr_q;
        ptr_d   = ptr_q;
        din_d   = din_q;
        din2_d  = din2_q;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (pick_vld) begin
                    state_d     = LAUNCH;
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    last_d      = pick;
                    retry_d     = '0;
                    start_d     = 1'b1;
                    rw_d        = Req_rw[pick];
                    sp_d        = Req_setptr[pick];
                    adr_d       = adr_a[pick];
                    ptr_d       = ptr_a[pick];
                    din_d       = wd_a[pick][7:0];
                    din2_d      = wd_a[pick][15:8];
                end
            end
            LAUNCH: begin
                // Master acknowledges start by dropping Ready.
                if (!M_ready) begin
                    state_d = WAIT_DONE;
                    start_d = 1'b0;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FINISH;
                    start_d = 1'b0;
                    done_d  = gnt_q;
                    stat_d  = 2'b10;
                    tmo_d   = '0;
                end
            end
            WAIT_DONE: begin
                if (M_ready) begin
                    rdata_d = {M_data_out2, M_data_out1};
                    tmo_d   = '0;
                    if (M_error && (retry_q < 8'(MAX_RETRY))) begin
                        state_d = GAP;
                        retry_d = retry_q + 8'd1;
                    end else begin
                        state_d = FINISH;
                        done_d  = gnt_q;
                        stat_d  = M_error ? 2'b01 : 2'b00;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = FINISH;
                    done_d  = gnt_q;
                    stat_d  = 2'b10;
                    tmo_d   = '0;
                end
            end
            GAP: begin
                if (tmo_q == GAP_LAST) begin
                    state_d = LAUNCH;
                    start_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            FINISH: begin
                state_d = IDLE;
                gnt_d   = '0;
                tmo_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            last_q  <= IW'(NREQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            stat_q  <= '0;
            rdata_q <= '0;
            tmo_q   <= '0;
            retry_q <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            rw_q    <= 1'b0;
            sp_q    <= 1'b0;
            adr_q   <= '0;
            ptr_q   <= '0;
            din_q   <= '0;
            din2_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
            busy_q  <= (state_d != IDLE);
            start_q <= start_d;
            rw_q    <= rw_d;
            sp_q    <= sp_d;
            adr_q   <= adr_d;
            ptr_q   <= ptr_d;
            din_q   <= din_d;
            din2_q  <= din2_d;
        end
    end

    assign Gnt           = gnt_q;
    assign Done          = done_q;
    assign Stat          = stat_q;
    assign Rdata         = rdata_q;
    assign Busy          = busy_q;
    assign M_start       = start_q;
    assign M_rw          = rw_q;
    assign M_set_pointer = sp_q;
    assign M_adr         = adr_q;
    assign M_pointer     = ptr_q;
    assign M_data_in     = din_q;
    assign M_data_in2    = din2_q;
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Scoreboard bench for i2c_bus_arbiter: behavioural master, round-robin reference model, decoupled monitor.
module tb_i2c_bus_arbiter;
    localparam int NREQ = 2, MAX_RETRY = 2, GAP_CYC = 8, TIMEOUT = 120;

    logic                Clk = 1'b0, Rst = 1'b1;
    logic [NREQ-1:0]     Req = '0, Req_rw = '0, Req_setptr = '0;
    logic [7*NREQ-1:0]   Req_adr = '0;
    logic [8*NREQ-1:0]   Req_pointer = '0;
    logic [16*NREQ-1:0]  Req_wdata = '0;
    logic [NREQ-1:0]     Gnt, Done;
    logic [1:0]          Stat;
    logic [15:0]         Rdata;
    logic                Busy, M_start, M_rw, M_set_pointer;
    logic [6:0]          M_adr;
    logic [7:0]          M_pointer, M_data_in, M_data_in2;
    logic                M_ready = 1'b1, M_error = 1'b0;
    logic [7:0]          M_data_out1 = '0, M_data_out2 = '0;

    i2c_bus_arbiter #(.NREQ(NREQ), .MAX_RETRY(MAX_RETRY), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .Req_adr(Req_adr), .Req_rw(Req_rw),
        .Req_pointer(Req_pointer), .Req_setptr(Req_setptr), .Req_wdata(Req_wdata),
        .Gnt(Gnt), .Done(Done), .Stat(Stat), .Rdata(Rdata), .Busy(Busy),
        .M_start(M_start), .M_rw(M_rw), .M_set_pointer(M_set_pointer), .M_adr(M_adr),
        .M_pointer(M_pointer), .M_data_in(M_data_in), .M_data_in2(M_data_in2),
        .M_ready(M_ready), .M_error(M_error), .M_data_out1(M_data_out1), .M_data_out2(M_data_out2)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          idx;
        logic [1:0]  stat;
        logic [15:0] rdata;
        int          starts;
        bit          stuck;
        logic [32:0] fields;
    } exp_t;

    exp_t q[$];
    int   tests = 0, fails = 0;

    // Per-requester behaviour and fields for the current batch
    int          cnt[NREQ], errs[NREQ];
    bit          stuck[NREQ], hang[NREQ];
    logic [7:0]  d1[NREQ], d2[NREQ], f_ptr[NREQ];
    logic [6:0]  f_adr[NREQ];
    logic        f_rw[NREQ], f_sp[NREQ];
    logic [15:0] f_wd[NREQ];
    int          drop_dly = 3, busy_dly = 10;
    int          m_last;
    logic [15:0] m_rdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] fields_of(input int i);
        return {f_adr[i], f_rw[i], f_sp[i], f_ptr[i], f_wd[i]};
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic randomize_req(input int i);
        f_adr[i] = 7'($urandom);
        f_rw[i]  = 1'($urandom);
        f_sp[i]  = 1'($urandom);
        f_ptr[i] = 8'($urandom);
        f_wd[i]  = 16'($urandom);
        d1[i]    = 8'($urandom);
        d2[i]    = 8'($urandom);
    endtask

    task automatic apply_fields();
        for (int i = 0; i < NREQ; i++) begin
            Req_adr[7*i +: 7]      = f_adr[i];
            Req_rw[i]              = f_rw[i];
            Req_setptr[i]          = f_sp[i];
            Req_pointer[8*i +: 8]  = f_ptr[i];
            Req_wdata[16*i +: 16]  = f_wd[i];
        end
    endtask

    task automatic default_batch();
        for (int i = 0; i < NREQ; i++) begin
            cnt[i] = 0; errs[i] = 0; stuck[i] = 0; hang[i] = 0;
            randomize_req(i);
        end
        drop_dly = $urandom_range(0, 5);
        busy_dly = $urandom_range(2, 60);
    endtask

    // Reference: serve pending requesters in round-robin order starting after the last winner.
    task automatic model_push(output int first);
        int c[NREQ];
        int left, j;
        exp_t e;
        first = -1;
        left  = 0;
        for (int i = 0; i < NREQ; i++) begin c[i] = cnt[i]; left += cnt[i]; end
        while (left > 0) begin
            j = -1;
            for (int k = 1; k <= NREQ && j < 0; k++)
                if (c[(m_last + k) % NREQ] > 0) j = (m_last + k) % NREQ;
            if (first < 0) first = j;
            e.idx = j; e.fields = fields_of(j); e.stuck = stuck[j];
            if (stuck[j] || hang[j]) begin
                e.stat = 2'b10; e.starts = 1; e.rdata = m_rdata;
            end else begin
                e.stat   = (errs[j] > MAX_RETRY) ? 2'b01 : 2'b00;
                e.starts = (errs[j] > MAX_RETRY) ? MAX_RETRY + 1 : errs[j] + 1;
                e.rdata  = {d2[j], d1[j]};
                m_rdata  = e.rdata;
            end
            q.push_back(e);
            c[j]--; left--; m_last = j;
        end
    endtask

    // Call right after a falling edge.
    task automatic run_batch();
        int first, guard, left;
        model_push(first);
        apply_fields();
        for (int i = 0; i < NREQ; i++) Req[i] = (cnt[i] > 0);
        @(negedge Clk);
        chk("grant_t1", {Busy, M_start, Gnt}, {1'b1, 1'b1, onehot(first)});
        guard = 0;
        left  = 1;
        while (left > 0 && guard < 20000) begin
            @(negedge Clk);
            guard++;
            left = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (Done[i] && cnt[i] > 0) begin
                    cnt[i]--;
                    if (cnt[i] == 0) begin
                        Req[i] = 1'b0;
                        randomize_req(i);
                        apply_fields();
                    end
                end
                left += cnt[i];
            end
        end
        if (left > 0) begin
            tests++; fails++;
            $display("FAIL batch_timeout: got %0d outstanding expected 0", left);
            Req = '0;
        end
        repeat (3) @(negedge Clk);
    endtask

    // Behavioural I2C master: Ready drops after Start, rises after busy_dly with per-attempt error.
    initial begin
        int ph, mc, att, g;
        ph = 0; mc = 0; att = 0; g = 0;
        forever begin
            @(posedge Clk);
            #1;
            if (Rst || Gnt == '0) begin
                M_ready = 1'b1; M_error = 1'b0; ph = 0; att = 0;
            end else begin
                for (int i = 0; i < NREQ; i++) if (Gnt[i]) g = i;
                case (ph)
                    0: if (M_start) begin mc = drop_dly; ph = 1; end
                    1: if (mc > 0) mc--;
                       else if (!stuck[g]) begin M_ready = 1'b0; M_error = 1'b0; mc = busy_dly; ph = 2; end
                    2: if (mc > 0) mc--;
                       else if (!hang[g]) begin
                           M_ready = 1'b1; M_error = (att < errs[g]);
                           M_data_out1 = d1[g]; M_data_out2 = d2[g];
                           att++; ph = 0;
                       end
                    default: ph = 0;
                endcase
            end
        end
    end

    // Monitor: checks launch fields and completion results against the scoreboard.
    initial begin
        int cyc, starts, hi, last_done;
        logic prev;
        exp_t e;
        cyc = 0; starts = 0; hi = 0; last_done = -100; prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                starts = 0; hi = 0; prev = 1'b0;
            end else begin
                cyc++;
                if (M_start && !prev) begin
                    starts++;
                    if (starts == 1) begin
                        chk("done_to_start_gap", 64'((cyc - last_done) >= 2), 64'd1);
                        if (q.size() > 0) begin
                            chk("launch_gnt", Gnt, onehot(q[0].idx));
                            chk("launch_fields", {M_adr, M_rw, M_set_pointer, M_pointer, M_data_in2, M_data_in}, q[0].fields);
                        end
                    end
                end
                if (M_start) hi++;
                if (Done != '0) begin
                    if (q.size() == 0) chk("unexpected_done", Done, '0);
                    else begin
                        e = q.pop_front();
                        chk("done_idx", {Gnt, Done}, {onehot(e.idx), onehot(e.idx)});
                        chk("stat", Stat, e.stat);
                        chk("rdata", Rdata, e.rdata);
                        chk("start_count", starts, e.starts);
                        chk("fields_held", {M_adr, M_rw, M_set_pointer, M_pointer, M_data_in2, M_data_in}, e.fields);
                        if (e.stuck) chk("start_high_cycles", hi, TIMEOUT);
                    end
                    starts = 0; hi = 0; last_done = cyc;
                end
                prev = M_start;
            end
        end
    end

    initial begin
        int guard;
        m_last  = NREQ - 1;
        m_rdata = '0;
        for (int i = 0; i < NREQ; i++) begin cnt[i] = 0; errs[i] = 0; stuck[i] = 0; hang[i] = 0; randomize_req(i); end
        repeat (3) @(negedge Clk);
        chk("reset_outputs", {Gnt, Done, Busy, M_start, M_rw, M_set_pointer, Stat, Rdata,
                              M_adr, M_pointer, M_data_in, M_data_in2}, '0);
        Rst = 1'b0;
        @(negedge Clk);

        // Round-robin, both held for two transactions each: 0,1,0,1
        default_batch(); cnt[0] = 2; cnt[1] = 2; run_batch();
        // Single write
        default_batch(); cnt[0] = 1; f_adr[0] = 7'h48; f_rw[0] = 1'b0; f_sp[0] = 1'b0; f_wd[0] = 16'hA55A;
        drop_dly = 3; busy_dly = 100; run_batch();
        // Read
        default_batch(); cnt[0] = 1; f_rw[0] = 1'b1; d1[0] = 8'h12; d2[0] = 8'h34; run_batch();
        // Error on every attempt
        default_batch(); cnt[1] = 1; errs[1] = MAX_RETRY + 1; run_batch();
        // Start never acknowledged, then Ready never returns
        default_batch(); cnt[0] = 1; stuck[0] = 1; run_batch();
        default_batch(); cnt[1] = 1; hang[1] = 1; run_batch();

        for (int b = 0; b < 16; b++) begin
            default_batch();
            for (int i = 0; i < NREQ; i++) begin
                int r;
                cnt[i]  = $urandom_range(0, 2);
                errs[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
                r = $urandom_range(0, 11);
                stuck[i] = (r == 0);
                hang[i]  = (r == 1);
            end
            if (cnt[0] == 0 && cnt[1] == 0) cnt[$urandom_range(0, NREQ - 1)] = 1;
            run_batch();
        end

        // Reset while waiting on the master
        default_batch(); drop_dly = 2; busy_dly = 60; apply_fields(); Req[0] = 1'b1;
        guard = 0;
        do begin @(negedge Clk); guard++; end while (!(Busy && !M_start && !M_ready) && guard < 200);
        chk("reached_wait_done", 64'(guard < 200), 64'd1);
        repeat (3) @(negedge Clk);
        #2 Rst = 1'b1;
        #1 chk("async_reset_outputs", {Gnt, Done, Busy, M_start, M_rw, M_set_pointer, Stat, Rdata,
                                       M_adr, M_pointer, M_data_in, M_data_in2}, '0);
        Req = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        m_last  = NREQ - 1;
        m_rdata = '0;
        default_batch(); cnt[1] = 1; run_batch();

        chk("scoreboard_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
